// File: rtl/io_pkg.sv
// Shared I/O-space constants and FSM encodings for the programmed-I/O echo controller.
package io_pkg;

  localparam logic [15:0] KBD_RSR = 16'h0000;
  localparam logic [15:0] KBD_RBR = 16'h0001;
  localparam logic [15:0] DSP_TSR = 16'h0002;
  localparam logic [15:0] DSP_TBR = 16'h0003;

  localparam int unsigned READY_BIT_IDX = 0;

  // Controller states
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StKStat = 3'd1;
  localparam logic [2:0] StKData = 3'd2;
  localparam logic [2:0] StDStat = 3'd3;
  localparam logic [2:0] StDData = 3'd4;

  // Bus access phases
  localparam logic [1:0] BcIdle  = 2'd0;
  localparam logic [1:0] BcSetup = 2'd1;
  localparam logic [1:0] BcStrb  = 2'd2;
  localparam logic [1:0] BcHold  = 2'd3;

endpackage

// File: rtl/io_bus_cycle.sv
// One programmed-I/O access: SETUP, STRB strobe-low cycles, HOLD. A new access may be
// started from HOLD so back-to-back accesses have no idle gap.
module io_bus_cycle
  import io_pkg::*;
#(
  parameter int unsigned IO_SIZE = 16,
  parameter int unsigned STRB    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               we_i,
  input  logic [IO_SIZE-1:0] a_i,
  input  logic [7:0]         wdata_i,
  input  logic [7:0]         rd_i,
  output logic [7:0]         rdata_o,
  output logic               done_o,
  output logic               busy_o,
  output logic [IO_SIZE-1:0] addr_o,
  output logic               ior_n_o,
  output logic               iow_n_o,
  output logic [7:0]         wdata_o,
  output logic               oe_o
);

  localparam int unsigned SW = (STRB > 1) ? $clog2(STRB) : 1;

  logic [1:0]         phase_q, phase_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [IO_SIZE-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_q, rdata_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (phase_q)
      BcIdle, BcHold: begin
        phase_d = BcIdle;
        if (start_i) begin
          phase_d = BcSetup;
          addr_d  = a_i;
          we_d    = we_i;
          wdata_d = wdata_i;
        end
      end
      BcSetup: begin
        phase_d = BcStrb;
        cnt_d   = '0;
      end
      BcStrb: begin
        if (cnt_q == SW'(STRB - 1)) begin
          phase_d = BcHold;
          if (!we_q) rdata_d = rd_i;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      default: phase_d = BcIdle;
    endcase
  end

  // Address is not cleared between accesses so it never glitches in idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q <= BcIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign done_o  = (phase_q == BcHold);
  assign busy_o  = (phase_q != BcIdle);
  assign addr_o  = addr_q;
  assign ior_n_o = !((phase_q == BcStrb) && !we_q);
  assign iow_n_o = !((phase_q == BcStrb) && we_q);
  assign wdata_o = wdata_q;
  assign oe_o    = we_q && (phase_q != BcIdle);

endmodule

// File: rtl/io_echo_ctrl.sv
// Programmed-I/O master that polls the keyboard, buffers received bytes and echoes them
// to the display, alternating between the two sides.
module io_echo_ctrl
  import io_pkg::*;
#(
  parameter int unsigned          IO_SIZE    = 16,
  parameter logic [IO_SIZE-1:0]   KBD_BASE   = IO_SIZE'(KBD_RSR),
  parameter logic [IO_SIZE-1:0]   DSP_BASE   = IO_SIZE'(DSP_TSR),
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter int unsigned          STRB       = 2,
  parameter int unsigned          READY_BIT  = READY_BIT_IDX
) (
  input  logic                        clock,
  input  logic                        reset_,
  input  logic                        enable,
  output logic [IO_SIZE-1:0]          addr,
  inout  wire  [7:0]                  d7_d0,
  output logic                        ior_,
  output logic                        iow_,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 chars_echoed
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [2:0]         state_q, state_d, pick;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [15:0]        chars_q, chars_d;
  logic               push, pop, pref_dsp, nonempty, notfull;
  logic               bus_start, bus_we, bus_done;
  logic [IO_SIZE-1:0] bus_a;
  logic [7:0]         bus_wdata, bus_rdata, d_out;
  logic               d_oe;

  always_comb begin
    push     = (state_q == StKData) && bus_done;
    pop      = (state_q == StDData) && bus_done;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    chars_d  = chars_q + 16'(pop);
    nonempty = (count_d != '0);
    notfull  = (count_d != CW'(FIFO_DEPTH));
    // Idle and keyboard ops favour the display side; display ops favour the keyboard.
    pref_dsp = (state_q == StIdle) || (state_q == StKStat) || (state_q == StKData);
    if (!enable)       pick = StIdle;
    else if (pref_dsp) pick = nonempty ? StDStat : (notfull ? StKStat : StIdle);
    else               pick = notfull ? StKStat : (nonempty ? StDStat : StIdle);

    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = pick;
      StKStat: if (bus_done) state_d = bus_rdata[READY_BIT] ? StKData : pick;
      StKData: if (bus_done) state_d = pick;
      StDStat: if (bus_done) state_d = bus_rdata[READY_BIT] ? StDData : pick;
      StDData: if (bus_done) state_d = pick;
      default: state_d = StIdle;
    endcase

    bus_start = (state_d != StIdle) && ((state_q == StIdle) || bus_done);
    bus_we    = (state_d == StDData);
    bus_wdata = mem_q[rd_ptr_q];
    unique case (state_d)
      StKData: bus_a = KBD_BASE + IO_SIZE'(1);
      StDStat: bus_a = DSP_BASE;
      StDData: bus_a = DSP_BASE + IO_SIZE'(1);
      default: bus_a = KBD_BASE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      chars_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      chars_q  <= chars_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus_rdata;
  end

  io_bus_cycle #(
    .IO_SIZE (IO_SIZE),
    .STRB    (STRB)
  ) u_bus (
    .clk_i   (clock),
    .rst_ni  (reset_),
    .start_i (bus_start),
    .we_i    (bus_we),
    .a_i     (bus_a),
    .wdata_i (bus_wdata),
    .rd_i    (d7_d0),
    .rdata_o (bus_rdata),
    .done_o  (bus_done),
    .busy_o  (busy),
    .addr_o  (addr),
    .ior_n_o (ior_),
    .iow_n_o (iow_),
    .wdata_o (d_out),
    .oe_o    (d_oe)
  );

  assign d7_d0        = d_oe ? d_out : 8'bz;
  assign fifo_count   = count_q;
  assign chars_echoed = chars_q;

endmodule

// File: tb/tb_io_echo_ctrl.sv
// Directed bench for io_echo_ctrl with behavioural keyboard/display models on the I/O bus.
module tb_io_echo_ctrl;

  logic        clock = 1'b0;
  logic        reset_, enable;
  wire  [7:0]  d7_d0;
  logic [15:0] addr;
  logic        ior_, iow_, busy;
  logic [2:0]  fifo_count;
  logic [15:0] chars_echoed;

  always #5 clock = ~clock;

  io_echo_ctrl dut (
    .clock        (clock),
    .reset_       (reset_),
    .enable       (enable),
    .addr         (addr),
    .d7_d0        (d7_d0),
    .ior_         (ior_),
    .iow_         (iow_),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .chars_echoed (chars_echoed)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  kq[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  writes[$];
  logic        key_avail = 1'b0;
  logic [7:0]  key_val = 8'h00;
  logic        tsr_ready = 1'b0;
  logic [7:0]  rd_val, wcap;
  int          rbr_reads = 0, ior_falls = 0, iow_falls = 0, iow_len = 0, iow_run = 0;
  logic        prev_ior = 1'b1, prev_iow = 1'b1;
  logic [15:0] prev_addr = 16'h0000;

  always_comb begin
    case (addr)
      16'h0000: rd_val = {7'b0, key_avail};
      16'h0001: rd_val = key_val;
      16'h0002: rd_val = {7'b0, tsr_ready};
      default:  rd_val = 8'h00;
    endcase
  end

  assign d7_d0 = (ior_ == 1'b0) ? rd_val : 8'bz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Device models plus bus protocol checks, all sampled on the falling edge.
  always @(negedge clock) begin
    if (reset_) begin
      if (!ior_ || !iow_) check("strobe_excl", {31'b0, ior_ | iow_}, 32'd1);
      if (!ior_) check("no_drive_on_read", {31'b0, dut.d_oe}, 32'd0);
      if (!iow_) check("drive_on_write", {31'b0, dut.d_oe}, 32'd1);
      if (!busy) check("no_drive_idle", {31'b0, dut.d_oe}, 32'd0);
      if ((!ior_ || !iow_) && (!prev_ior || !prev_iow))
        check("addr_stable", {16'b0, addr}, {16'b0, prev_addr});
    end
    if (!iow_) wcap = d7_d0;
    if (prev_ior && !ior_) ior_falls++;
    if (prev_iow && !iow_) iow_falls++;
    if (!iow_) iow_run++;
    else if (!prev_iow) begin
      iow_len = iow_run;
      iow_run = 0;
    end
    if (!prev_ior && ior_ && prev_addr == 16'h0001 && kq.size() > 0) begin
      void'(kq.pop_front());
      rbr_reads++;
    end
    if (!prev_iow && iow_ && prev_addr == 16'h0003) writes.push_back(wcap);
    key_avail = (kq.size() != 0);
    key_val   = (kq.size() != 0) ? kq[0] : 8'h00;
    prev_ior  = ior_;
    prev_iow  = iow_;
    prev_addr = addr;
  end

  task automatic type_key(input logic [7:0] k);
    kq.push_back(k);
    exp_q.push_back(k);
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (writes.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, writes.size(), n);
  endtask

  task automatic stop_and_idle(input string tag);
    int k = 0;
    @(posedge clock);
    #1 enable = 1'b0;
    @(negedge clock);
    while (busy && k < 40) begin
      @(negedge clock);
      k++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n, base, snap;
    reset_ = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ior", {31'b0, ior_}, 32'd1);
    check("rst_iow", {31'b0, iow_}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_addr", {16'b0, addr}, 32'd0);
    check("rst_count", {29'b0, fifo_count}, 32'd0);
    check("rst_chars", {16'b0, chars_echoed}, 32'd0);

    // Reset asserted in the middle of an RSR read
    reset_ = 1'b1;
    enable = 1'b1;
    n = 0;
    while (ior_ !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("midread_seen", {31'b0, ior_}, 32'd0);
    reset_ = 1'b0;
    @(negedge clock);
    check("midrst_ior", {31'b0, ior_}, 32'd1);
    check("midrst_iow", {31'b0, iow_}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_oe", {31'b0, dut.d_oe}, 32'd0);
    check("midrst_count", {29'b0, fifo_count}, 32'd0);
    enable = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;
    repeat (2) @(negedge clock);

    // Single echo with exact access timing
    @(posedge clock);
    #1 type_key(8'h41);
    tsr_ready = 1'b1;
    @(posedge clock);
    #1 enable = 1'b1;
    repeat (9) @(posedge clock);
    @(negedge clock);
    check("echo_pushed", {29'b0, fifo_count}, 32'd1);
    check("echo_rbr_reads", rbr_reads, 32'd1);
    repeat (7) @(posedge clock);
    @(negedge clock);
    check("echo_chars_pre", {16'b0, chars_echoed}, 32'd0);
    @(negedge clock);
    check("echo_chars", {16'b0, chars_echoed}, 32'd1);
    check("echo_count", {29'b0, fifo_count}, 32'd0);
    check("echo_nwrites", writes.size(), 32'd1);
    check("echo_byte", {24'b0, writes[0]}, 32'h41);
    check("echo_iow_len", iow_len, 32'd2);
    stop_and_idle("echo_idle");

    // Display stalled: FIFO fills, keyboard left alone, then drains in order
    @(posedge clock);
    #1 tsr_ready = 1'b0;
    for (int i = 0; i < 6; i++) type_key(8'h30 + 8'(i));
    enable = 1'b1;
    repeat (120) @(negedge clock);
    check("stall_full", {29'b0, fifo_count}, 32'd4);
    check("stall_reads", rbr_reads, 32'd5);
    check("stall_nowrite", writes.size(), 32'd1);
    repeat (40) @(negedge clock);
    check("stall_reads_hold", rbr_reads, 32'd5);
    check("stall_kq_left", kq.size(), 32'd2);
    @(posedge clock);
    #1 tsr_ready = 1'b1;
    wait_writes(7, 400, "stall_drain");
    for (int i = 0; i < 6; i++) check("stall_order", {24'b0, writes[1+i]}, 32'h30 + i);
    @(negedge clock);
    check("stall_chars", {16'b0, chars_echoed}, 32'd7);
    stop_and_idle("stall_idle");

    // enable dropped after K_STAT has seen ready: K_DATA still completes
    @(posedge clock);
    #1 type_key(8'h55);
    tsr_ready = 1'b1;
    @(posedge clock);
    #1 enable = 1'b1;
    repeat (4) @(posedge clock);
    #1 enable = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("drop_count", {29'b0, fifo_count}, 32'd1);
    check("drop_busy", {31'b0, busy}, 32'd0);
    check("drop_reads", rbr_reads, 32'd8);
    snap = ior_falls + iow_falls;
    repeat (20) @(negedge clock);
    check("drop_quiet", ior_falls + iow_falls, snap);

    // Random traffic under the protocol checker
    @(posedge clock);
    #1 enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock);
      #1 type_key(8'($urandom_range(0, 255)));
      tsr_ready = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 16)) @(posedge clock);
    end
    #1 tsr_ready = 1'b1;
    wait_writes(exp_q.size(), 40000, "rand_drain");
    for (int i = 0; i < exp_q.size(); i++)
      check("rand_order", {24'b0, writes[i]}, {24'b0, exp_q[i]});
    stop_and_idle("rand_idle");

    // Counter wrap and FIFO pointer wrap
    @(posedge clock);
    #1 force dut.chars_q = 16'hFFFD;
    @(negedge clock);
    release dut.chars_q;
    @(negedge clock);
    check("wrap_preset", {16'b0, chars_echoed}, 32'hFFFD);
    base = writes.size();
    @(posedge clock);
    #1 tsr_ready = 1'b0;
    for (int i = 0; i < 5; i++) type_key(8'hA0 + 8'(i));
    enable = 1'b1;
    repeat (100) @(negedge clock);
    check("wrap_full", {29'b0, fifo_count}, 32'd4);
    @(posedge clock);
    #1 tsr_ready = 1'b1;
    wait_writes(base + 2, 400, "wrap_w2");
    @(negedge clock);
    check("wrap_ffff", {16'b0, chars_echoed}, 32'hFFFF);
    wait_writes(base + 3, 400, "wrap_w3");
    @(negedge clock);
    check("wrap_zero", {16'b0, chars_echoed}, 32'h0000);
    wait_writes(base + 5, 400, "wrap_w5");
    @(negedge clock);
    check("wrap_final", {16'b0, chars_echoed}, 32'h0002);
    for (int i = 0; i < 5; i++) check("wrap_order", {24'b0, writes[base+i]}, 32'hA0 + i);
    stop_and_idle("wrap_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
